// File: rtl/ahb_to_fpga_sram_if.sv
// AHB-Lite zero-wait-state bridge to a 1-cycle registered-read, byte-write FPGA SRAM.
// Optional access counters are built when AHB_SRAM_ACCESS_CNT_EN is defined.
module ahb_to_fpga_sram_if #(
  parameter int AW = 18
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW-1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  output logic [31:0]   RDCNT,
  output logic [31:0]   WRCNT
);

  logic          accepted;
  logic          rd_ap;
  logic          wr_ap;
  logic          commit;
  logic          merge_hit;
  logic [3:0]    byte_en;
  logic [AW-3:0] wr_addr;
  logic [3:0]    wr_we;
  logic          wr_dph;
  logic [31:0]   buf_data;
  logic          buf_pend;
  logic          rd_dph;
  logic [AW-3:0] rd_addr;
  logic          unused_inputs;

  assign unused_inputs = &{1'b0, HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign accepted = HSEL & HREADY & HTRANS[1];
  assign rd_ap    = accepted & ~HWRITE;
  assign wr_ap    = accepted & HWRITE;
  // Reads own the SRAM port; a buffered write only drains on non-read cycles.
  assign commit   = buf_pend & ~rd_ap;

  always_comb begin
    byte_en = 4'b1111;
    case (HSIZE)
      3'd0:    byte_en = 4'b0001 << HADDR[1:0];
      3'd1:    byte_en = HADDR[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_addr  <= '0;
      wr_we    <= '0;
      wr_dph   <= 1'b0;
      buf_data <= '0;
      buf_pend <= 1'b0;
      rd_dph   <= 1'b0;
      rd_addr  <= '0;
    end else begin
      wr_dph <= wr_ap;
      rd_dph <= rd_ap;
      if (wr_ap) begin
        wr_addr <= HADDR[AW-1:2];
        wr_we   <= byte_en;
      end
      if (rd_ap) rd_addr <= HADDR[AW-1:2];
      if (wr_dph) buf_data <= HWDATA;
      if (wr_ap) buf_pend <= 1'b1;
      else if (commit) buf_pend <= 1'b0;
    end
  end

  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = HADDR[AW-1:2];
    SRAMWDATA = buf_data;
    if (rd_ap) begin
      SRAMCS = 1'b1;
    end else if (buf_pend) begin
      SRAMCS    = 1'b1;
      SRAMWEN   = wr_we;
      SRAMADDR  = wr_addr;
      SRAMWDATA = wr_dph ? HWDATA : buf_data;
    end
  end

  // Bytes still sitting in the write buffer override stale SRAM read data.
  assign merge_hit = buf_pend & (rd_addr == wr_addr);

  always_comb begin
    HRDATA = 32'h0;
    if (rd_dph) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (merge_hit && wr_we[i]) ? buf_data[8*i +: 8] : SRAMRDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SRAM_ACCESS_CNT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      RDCNT <= 32'h0;
      WRCNT <= 32'h0;
    end else begin
      if (rd_ap) RDCNT <= RDCNT + 32'd1;
      if (wr_ap) WRCNT <= WRCNT + 32'd1;
    end
  end
`else
  assign RDCNT = 32'h0;
  assign WRCNT = 32'h0;
`endif

endmodule

// File: tb/tb_ahb_to_fpga_sram_if.sv
// Bench for ahb_to_fpga_sram_if: a flat byte-addressable memory model predicts every read,
// with an SRAM model behind the bridge and directed literal checks from the test plan.
module tb_ahb_to_fpga_sram_if;
  localparam int AW = 18;
`ifdef AHB_SRAM_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic          HREADY = 1'b1;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic          HWRITE = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-3:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;
  logic [31:0]   RDCNT;
  logic [31:0]   WRCNT;

  bit        bd_we = 1'b0;
  bit [15:0] bd_addr = '0;
  bit [31:0] bd_data = '0;
  bit [31:0] sram_mem [65536];
  bit [31:0] golden [65536];
  logic [31:0] next_wdata = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  ahb_to_fpga_sram_if #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS),
    .RDCNT(RDCNT), .WRCNT(WRCNT)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural block RAM: registered read, byte-lane writes, plus a backdoor preload port.
  always @(posedge HCLK) begin
    if (bd_we) begin
      sram_mem[bd_addr] <= bd_data;
    end else if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= sram_mem[SRAMADDR];
      else for (int i = 0; i < 4; i++)
        if (SRAMWEN[i]) sram_mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit [3:0] laneMask(input logic [2:0] size, input logic [1:0] lo);
    int nbytes;
    int first;
    bit [3:0] m;
    nbytes = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    first  = (int'(lo) / nbytes) * nbytes;
    m = 4'b0000;
    for (int i = 0; i < nbytes; i++) m[first + i] = 1'b1;
    return m;
  endfunction

  // Reference: bus-visible memory updated at each write data phase; reads return its contents.
  initial begin : compare
    bit        prev_rd;
    bit        prev_wr;
    bit [15:0] prev_raddr;
    bit [15:0] prev_waddr;
    bit [3:0]  prev_mask;
    int unsigned rd_seen;
    int unsigned wr_seen;
    bit        acc;
    prev_rd = 0; prev_wr = 0; rd_seen = 0; wr_seen = 0;
    prev_raddr = '0; prev_waddr = '0; prev_mask = '0;
    forever begin
      @(negedge HCLK);
      checkOutput("hreadyout", {31'h0, HREADYOUT}, 32'h1);
      checkOutput("hresp", {31'h0, HRESP}, 32'h0);
      if (!HRESETn) begin
        checkOutput("reset_hrdata", HRDATA, 32'h0);
        checkOutput("reset_sramwen", {28'h0, SRAMWEN}, 32'h0);
        checkOutput("reset_rdcnt", RDCNT, 32'h0);
        checkOutput("reset_wrcnt", WRCNT, 32'h0);
        prev_rd = 0; prev_wr = 0; rd_seen = 0; wr_seen = 0;
      end else begin
        if (bd_we) golden[bd_addr] = bd_data;
        checkOutput("hrdata", HRDATA, prev_rd ? golden[prev_raddr] : 32'h0);
        if (prev_wr)
          for (int i = 0; i < 4; i++)
            if (prev_mask[i]) golden[prev_waddr][8*i +: 8] = HWDATA[8*i +: 8];
        acc = HSEL && HREADY && HTRANS[1];
        if (acc && !HWRITE) begin
          checkOutput("read_cs", {31'h0, SRAMCS}, 32'h1);
          checkOutput("read_wen", {28'h0, SRAMWEN}, 32'h0);
          checkOutput("read_addr", {16'h0, SRAMADDR}, {16'h0, HADDR[17:2]});
        end
        if (!SRAMCS) checkOutput("idle_wen", {28'h0, SRAMWEN}, 32'h0);
        checkOutput("rdcnt", RDCNT, CNT_EN ? rd_seen : 32'h0);
        checkOutput("wrcnt", WRCNT, CNT_EN ? wr_seen : 32'h0);
        if (acc && !HWRITE) rd_seen++;
        if (acc && HWRITE) wr_seen++;
        prev_rd    = acc && !HWRITE;
        prev_wr    = acc && HWRITE;
        prev_raddr = HADDR[17:2];
        prev_waddr = HADDR[17:2];
        prev_mask  = laneMask(HSIZE, HADDR[1:0]);
      end
    end
  end

  // kind: 0 idle, 1 read, 2 write, 3 unselected transfer, 4 BUSY transfer
  task automatic applyStimulus(input int kind, input logic [2:0] size, input logic [AW-1:0] addr,
                               input logic [31:0] data, input bit ready);
    @(posedge HCLK);
    #1;
    bd_we  = 1'b0;
    HWDATA = next_wdata;
    HSEL   = (kind == 1 || kind == 2 || kind == 4);
    HTRANS = (kind == 1 || kind == 2 || kind == 3) ? {1'b1, 1'($urandom_range(0, 1))} :
             (kind == 4) ? 2'b01 : 2'b00;
    HWRITE = (kind == 2) || ((kind >= 3) && ($urandom_range(0, 1) == 1));
    HSIZE  = size;
    HADDR  = addr;
    HREADY = ready;
    next_wdata = (kind == 2 && ready) ? data : $urandom();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
  endtask

  task automatic prefill(input bit [15:0] waddr, input bit [31:0] wdata);
    idle(1);
    bd_we = 1'b1; bd_addr = waddr; bd_data = wdata;
    idle(1);
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(2);

    // Word write then read back
    applyStimulus(2, 3'd2, 18'h00100, 32'h11223344, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t1_wen", {28'h0, SRAMWEN}, 32'hF);
    checkOutput("t1_addr", {16'h0, SRAMADDR}, 32'h40);
    checkOutput("t1_wdata", SRAMWDATA, 32'h11223344);
    idle(1);
    applyStimulus(1, 3'd2, 18'h00100, 32'h0, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t1_hrdata", HRDATA, 32'h11223344);

    // Two byte writes into a cleared word
    prefill(16'h0080, 32'h0);
    applyStimulus(2, 3'd0, 18'h00201, 32'h0000AA00, 1'b1);
    applyStimulus(2, 3'd0, 18'h00203, 32'hBB000000, 1'b1);
    settle();
    checkOutput("t2_wen_a", {28'h0, SRAMWEN}, 32'h2);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t2_wen_b", {28'h0, SRAMWEN}, 32'h8);
    applyStimulus(1, 3'd2, 18'h00200, 32'h0, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t2_hrdata", HRDATA, 32'hBB00AA00);

    // Write held in buffer across three reads of the same word
    prefill(16'h00C0, 32'h01020304);
    applyStimulus(2, 3'd2, 18'h00300, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'd2, 18'h00300, 32'h0, 1'b1);
      settle();
      checkOutput("t3_wen_rd", {28'h0, SRAMWEN}, 32'h0);
      if (i > 0) checkOutput("t3_hrdata", HRDATA, 32'hDEADBEEF);
    end
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t3_hrdata_last", HRDATA, 32'hDEADBEEF);
    checkOutput("t3_commit_wen", {28'h0, SRAMWEN}, 32'hF);
    checkOutput("t3_commit_data", SRAMWDATA, 32'hDEADBEEF);

    // Halfword merge
    prefill(16'h0100, 32'h12345678);
    applyStimulus(2, 3'd1, 18'h00402, 32'hCAFE0000, 1'b1);
    applyStimulus(1, 3'd2, 18'h00400, 32'h0, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t4_hrdata", HRDATA, 32'hCAFE5678);

    // Reset during a write data phase discards the write
    prefill(16'h0140, 32'h0);
    applyStimulus(2, 3'd0, 18'h00500, 32'h00000055, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    HRESETn = 1'b0;
    settle();
    checkOutput("t5_rst_hrdata", HRDATA, 32'h0);
    checkOutput("t5_rst_wen", {28'h0, SRAMWEN}, 32'h0);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    HRESETn = 1'b1;
    applyStimulus(1, 3'd2, 18'h00500, 32'h0, 1'b1);
    applyStimulus(0, 3'd2, '0, 32'h0, 1'b1);
    settle();
    checkOutput("t5_hrdata", HRDATA, 32'h0);
    checkOutput("t5_sram_untouched", sram_mem[16'h0140], 32'h0);

    // Randomized traffic over a low and a high address window
    for (int n = 0; n < 800; n++) begin
      int k;
      int kind;
      logic [AW-1:0] a;
      k = $urandom_range(0, 9);
      kind = (k < 2) ? 0 : (k < 5) ? 1 : (k < 8) ? 2 : (k == 8) ? 3 : 4;
      a = ($urandom_range(0, 3) == 0) ? (18'h3FFC0 | 18'($urandom_range(0, 63))) : 18'($urandom_range(0, 63));
      applyStimulus(kind, 3'($urandom_range(0, 7)), a, $urandom(), $urandom_range(0, 7) != 0);
    end
    idle(4);

    // Access counters from a fresh reset
    @(posedge HCLK); #1 HRESETn = 1'b0;
    idle(2);
    HRESETn = 1'b1;
    applyStimulus(1, 3'd2, 18'h00000, 32'h0, 1'b1);
    applyStimulus(2, 3'd2, 18'h00004, 32'hA5A5A5A5, 1'b1);
    applyStimulus(1, 3'd2, 18'h00004, 32'h0, 1'b0);
    applyStimulus(1, 3'd0, 18'h00005, 32'h0, 1'b1);
    applyStimulus(2, 3'd1, 18'h00008, 32'h5A5A5A5A, 1'b1);
    applyStimulus(1, 3'd2, 18'h00008, 32'h0, 1'b1);
    applyStimulus(2, 3'd2, 18'h0000C, 32'h0F0F0F0F, 1'b0);
    applyStimulus(1, 3'd2, 18'h0000C, 32'h0, 1'b1);
    applyStimulus(2, 3'd2, 18'h0000C, 32'h12121212, 1'b1);
    applyStimulus(1, 3'd2, 18'h0000C, 32'h0, 1'b1);
    idle(2);
    settle();
    checkOutput("t6_rdcnt", RDCNT, CNT_EN ? 32'd5 : 32'd0);
    checkOutput("t6_wrcnt", WRCNT, CNT_EN ? 32'd3 : 32'd0);
    idle(3);
    settle();

    // Everything buffered must have drained into the SRAM
    for (int w = 0; w < 16; w++) begin
      checkOutput("drain_low", sram_mem[w], golden[w]);
      checkOutput("drain_high", sram_mem[16'hFFF0 + w], golden[16'hFFF0 + w]);
    end
    checkOutput("drain_t1", sram_mem[16'h0040], 32'h11223344);
    checkOutput("drain_t2", sram_mem[16'h0080], 32'hBB00AA00);
    checkOutput("drain_t3", sram_mem[16'h00C0], 32'hDEADBEEF);
    checkOutput("drain_t4", sram_mem[16'h0100], 32'hCAFE5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
